prominence_stream_out: RTL and testbench

// - AXI-Stream master that reads prominence results from the 3-field result buffer and streams them out as one frame.
// - Buffer layout: prominence at {2'b00,i}, peak value at {2'b01,i}, sample index at {2'b10,i}.
// - Sits between the prominence buffer's sequencer-side read port and the downstream DMA/FIFO; transmit-side counterpart of the analyser's AXI-Stream slave.

---
 rtl/prominence_stream_out.sv | 170 +++++++++++++++++
 tb/tb_prominence_stream_out.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prominence_stream_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : prominence_stream_out
// Description : AXI-Stream master that reads prominence results from the
//               3-field result buffer and streams them out as one frame.
//               Buffer layout: prominence at {2'b00,i}, peak value at
//               {2'b01,i}, sample index at {2'b10,i}. Beat order per entry is
//               prominence, peak value, index (index zero-extended from
//               10 bits).
// Options     : PROM_STREAM_HDR_EN - when defined, the frame starts with a
//               header beat carrying N (tuser_m=1); entry beats then have
//               tuser_m=0 and N==0 yields a single header-only beat.
// Ports       : clk, reset_n (async, active-low), ce (clock enable)
//               start/count          frame request and entry count N
//               busy/done            frame status, done is a 1-cycle pulse
//               buf_addr/buf_rd      buffer read port, buf_rdata 1 cycle later
//               tdata_m/tuser_m/tlast_m/tvalid_m/tready_m  AXI-Stream master
// Revision    : 1.0 - initial release
// ============================================================================
module prominence_stream_out #(
    parameter int DW = 16,
    parameter int AW = 10,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] buf_addr,
    output logic          buf_rd,
    input  logic [DW-1:0] buf_rdata,
    output logic [DW-1:0] tdata_m,
    output logic          tuser_m,
    output logic          tlast_m,
    output logic          tvalid_m,
    input  logic          tready_m
);

    localparam int EW = AW - 2;  // entry part of the buffer address

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] n_lat, n_lat_n;
    logic [CW-1:0] entry, entry_n;
    logic [1:0]    field, field_n;
    logic [DW-1:0] tdata_n;
    logic          tuser_n, tlast_n, tvalid_n;
    logic          first_beat;
`ifdef PROM_STREAM_HDR_EN
    logic          hdr, hdr_n;      // beat in SEND is the header, not an entry
`endif

    // Status and buffer port are pure decodes of the state so they are 0
    // whenever the FSM sits in IDLE (including straight out of reset).
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign buf_rd   = (state == READ);
    assign buf_addr = buf_rd ? {field, EW'(entry)} : '0;

`ifdef PROM_STREAM_HDR_EN
    assign first_beat = 1'b0;       // the header carries the frame start
`else
    assign first_beat = (entry == '0) && (field == 2'd0);
`endif

    always_comb begin
        state_n  = state;
        n_lat_n  = n_lat;
        entry_n  = entry;
        field_n  = field;
        tdata_n  = tdata_m;
        tuser_n  = tuser_m;
        tlast_n  = tlast_m;
        tvalid_n = tvalid_m;
`ifdef PROM_STREAM_HDR_EN
        hdr_n    = hdr;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    n_lat_n = count;
                    entry_n = '0;
                    field_n = 2'd0;
`ifdef PROM_STREAM_HDR_EN
                    // Header needs no buffer read, so it goes straight out.
                    tdata_n  = {{(DW-CW){1'b0}}, count};
                    tuser_n  = 1'b1;
                    tlast_n  = (count == '0);
                    tvalid_n = 1'b1;
                    hdr_n    = 1'b1;
                    state_n  = SEND;
`else
                    state_n  = (count == '0) ? DONE : READ;
`endif
                end
            end
            READ: state_n = CAPT;
            CAPT: begin
                // Index field is only 10 bits wide in the buffer.
                tdata_n  = (field == 2'd2) ? {{(DW-10){1'b0}}, buf_rdata[9:0]}
                                           : buf_rdata;
                tuser_n  = first_beat;
                tlast_n  = (entry == n_lat - CW'(1)) && (field == 2'd2);
                tvalid_n = 1'b1;
                state_n  = SEND;
            end
            SEND: begin
                if (tready_m) begin
                    tvalid_n = 1'b0;
                    tuser_n  = 1'b0;
`ifdef PROM_STREAM_HDR_EN
                    if (hdr) begin
                        hdr_n = 1'b0;
                    end else
`endif
                    if (field < 2'd2) begin
                        field_n = field + 2'd1;
                    end else begin
                        field_n = 2'd0;
                        entry_n = entry + CW'(1);
                    end
                    state_n = tlast_m ? DONE : READ;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            n_lat    <= '0;
            entry    <= '0;
            field    <= 2'd0;
            tdata_m  <= '0;
            tuser_m  <= 1'b0;
            tlast_m  <= 1'b0;
            tvalid_m <= 1'b0;
`ifdef PROM_STREAM_HDR_EN
            hdr      <= 1'b0;
`endif
        end else if (ce) begin
            state    <= state_n;
            n_lat    <= n_lat_n;
            entry    <= entry_n;
            field    <= field_n;
            tdata_m  <= tdata_n;
            tuser_m  <= tuser_n;
            tlast_m  <= tlast_n;
            tvalid_m <= tvalid_n;
`ifdef PROM_STREAM_HDR_EN
            hdr      <= hdr_n;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prominence_stream_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_prominence_stream_out
// Description : Scoreboard bench for prominence_stream_out. Frames are
//               predicted from a buffer image into an expected-beat queue;
//               a negedge monitor pops and compares on every transfer and
//               checks that stalled beats stay stable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prominence_stream_out;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int CW = 8;
    localparam int NE = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          busy, done, buf_rd;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_rdata = '0;
    logic [DW-1:0] tdata_m;
    logic          tuser_m, tlast_m, tvalid_m;
    logic          tready_m = 1'b1;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    prominence_stream_out #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .start(start), .count(count),
        .busy(busy), .done(done), .buf_addr(buf_addr), .buf_rd(buf_rd),
        .buf_rdata(buf_rdata), .tdata_m(tdata_m), .tuser_m(tuser_m),
        .tlast_m(tlast_m), .tvalid_m(tvalid_m), .tready_m(tready_m)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer: data one cycle after the read strobe.
    always @(posedge clk) if (buf_rd) buf_rdata <= mem[buf_addr];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    beat_t expq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    done_cnt = 0;
    int    beats = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: 4-cycle stall per beat
    int    ce_mode = 0;    // 0: always on, 1: toggle, 2: random

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: the frame is the buffer contents in entry order, three
    // fields per entry, index field limited to 10 bits.
    function automatic void push_frame(input int n);
        beat_t b;
`ifdef PROM_STREAM_HDR_EN
        b.data = DW'(n);
        b.user = 1'b1;
        b.last = (n == 0);
        expq.push_back(b);
`endif
        for (int e = 0; e < n; e++) begin
            for (int f = 0; f < 3; f++) begin
                b.data = mem[f * NE + e];
                if (f == 2) b.data = b.data % 1024;
`ifdef PROM_STREAM_HDR_EN
                b.user = 1'b0;
`else
                b.user = (e == 0) && (f == 0);
`endif
                b.last = (e == n - 1) && (f == 2);
                expq.push_back(b);
            end
        end
    endfunction

    // Ready / clock-enable generator, updated just after each edge.
    int   stall = 0;
    logic prev_v = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: tready_m = 1'b1;
            1: tready_m = 1'($urandom_range(0, 1));
            default: begin
                if (tvalid_m && !prev_v) stall = 4;
                tready_m = (stall == 0);
                if (stall > 0) stall--;
            end
        endcase
        prev_v = tvalid_m;
        case (ce_mode)
            0: ce = 1'b1;
            1: ce = ~ce;
            default: ce = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: inputs only change just after posedge, so negedge values are
    // exactly what the next edge will see.
    beat_t held;
    logic  held_v = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                vectors++;
                if (!tvalid_m || tdata_m !== held.data || tuser_m !== held.user || tlast_m !== held.last) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%0b d=%h u=%0b l=%0b expected v=1 d=%h u=%0b l=%0b",
                             tvalid_m, tdata_m, tuser_m, tlast_m, held.data, held.user, held.last);
                end
            end
            if (!buf_rd && buf_addr != '0) begin
                miscompares++;
                $display("FAIL addr_idle: got %h expected 0", buf_addr);
            end
            if (ce && tvalid_m && tready_m) begin
                beat_t e;
                vectors++;
                beats++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got d=%h u=%0b l=%0b expected no beat", tdata_m, tuser_m, tlast_m);
                end else begin
                    e = expq.pop_front();
                    if (tdata_m !== e.data || tuser_m !== e.user || tlast_m !== e.last) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h u=%0b l=%0b expected d=%h u=%0b l=%0b",
                                 tdata_m, tuser_m, tlast_m, e.data, e.user, e.last);
                    end
                end
                held_v = 1'b0;
            end else begin
                held_v = tvalid_m;
                held   = '{tdata_m, tuser_m, tlast_m};
            end
            if (done && ce) done_cnt++;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    endtask

    task automatic fill_t1();
        mem[0] = 16'd5;  mem[NE] = 16'd100; mem[2*NE] = 16'd17;
        mem[1] = 16'd9;  mem[NE+1] = 16'd200; mem[2*NE+1] = 16'd40;
    endtask

    task automatic start_frame(input int n);
        push_frame(n);
        count = CW'(n);
        start = 1'b1;
        do @(posedge clk); while (!ce);
        #1;
        start = 1'b0;
        count = CW'($urandom);  // must not affect the running frame
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_frame(input int n, input bit lat_chk, input bit poke);
        int d0;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        d0 = done_cnt;
        start_frame(n);
        if (lat_chk) begin
`ifdef PROM_STREAM_HDR_EN
            chk("hdr_valid_after_start", 32'(tvalid_m), 32'd1);
`else
            if (n == 0) begin
                chk("n0_done", 32'(done), 32'd1);
                chk("n0_no_valid", 32'(tvalid_m), 32'd0);
            end else begin
                chk("lat_edge1", 32'(tvalid_m), 32'd0);
                @(posedge clk); #1;
                chk("lat_edge1b", 32'(tvalid_m), 32'd0);
                @(posedge clk); #1;
                chk("lat_edge2", 32'(tvalid_m), 32'd1);
            end
`endif
        end
        if (poke && busy) begin
            start = 1'b1;
            count = CW'($urandom_range(1, 9));
            repeat (2) @(posedge clk);
            #1;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 30 * (3 * n + 4) + 200) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == d0) begin
            miscompares++;
            $display("FAIL frame_timeout: got no done after %0d cycles expected done", cyc);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("one_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(tvalid_m), 32'd0);
        expq.delete();
    endtask

    initial begin
        fill_random();
        // Reset state
        #12;
        chk("rst_valid", 32'(tvalid_m), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd", 32'(buf_rd), 32'd0);
        chk("rst_addr", 32'(buf_addr), 32'd0);
        chk("rst_data", 32'(tdata_m), 32'd0);
        chk("rst_user_last", 32'({tuser_m, tlast_m}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: fixed two-entry frame, ready high, latency checked
        fill_t1();
        rdy_mode = 0; ce_mode = 0;
        run_frame(2, 1'b1, 1'b0);

        // T2: backpressure on every beat
        fill_random();
        rdy_mode = 2;
        run_frame(1, 1'b0, 1'b0);

        // T3: ce toggling on the T1 frame
        fill_t1();
        rdy_mode = 0; ce_mode = 1;
        run_frame(2, 1'b0, 1'b0);

        // T4: empty frame
        ce_mode = 0;
        run_frame(0, 1'b1, 1'b0);

        // T5: reset during the second beat's stall, then a clean frame
        fill_random();
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        begin
            int b0;
            int cyc;
            b0 = beats;
            start_frame(3);
            cyc = 0;
            while (!(beats == b0 + 1 && tvalid_m && !tready_m) && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("t5_reached_stall", 32'(cyc < 200), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("t5_valid_on_reset", 32'(tvalid_m), 32'd0);
        chk("t5_busy_on_reset", 32'(busy), 32'd0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(3, 1'b0, 1'b0);

        // T6: saturated index words and start pulsed while busy
        fill_random();
        for (int e = 0; e < 4; e++) mem[2 * NE + e] = 16'hFFFF;
        rdy_mode = 1; ce_mode = 0;
        run_frame(4, 1'b0, 1'b1);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            fill_random();
            rdy_mode = $urandom_range(0, 2);
            ce_mode  = $urandom_range(0, 2);
            run_frame($urandom_range(1, 20), 1'b0, 1'($urandom_range(0, 1)));
        end

        // Maximum entry count
        fill_random();
        rdy_mode = 0; ce_mode = 0;
        run_frame((1 << CW) - 1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
